decodificador_scan_code: RTL and testbench

// - Downstream consumer of the PS/2 byte receiver; takes each rx_done_tick + 8-bit scan byte (Set 2).
// - Strips E0 (extended), F0 (break) and E1 (pause) prefixes and emits one key event per physical make/break.
// - Queues events in a FWFT FIFO read by the game/control logic.
// - Drives rx_en back to the receiver so no bytes are accepted while the FIFO is full.

---
 rtl/decodificador_scan_code.sv | 144 ++++++++++++++
 tb/tb_decodificador_scan_code.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_scan_code.sv
// PS/2 Set 2 scan-code decoder: folds E0/F0/E1 prefixes into one key event per
// make/break and queues the events in a first-word-fall-through FIFO.
module decodificador_scan_code #(
  parameter int FIFO_AW   = 3,
  parameter int PAUSE_LEN = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  input  logic       evt_rd,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_ovf,
  input  logic       ovf_clr
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam int CW    = $clog2(PAUSE_LEN + 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          push;
  evt_t          push_evt;
  logic          is_prefix, is_noise;

  assign is_prefix = rx_data inside {8'hE0, 8'hF0, 8'hE1};
  assign is_noise  = rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    push     = 1'b0;
    push_evt = '0;
    if (rx_done_tick) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'hE0) state_n = EXT;
          else if (rx_data == 8'hF0) state_n = BRK;
          else if (rx_data == 8'hE1) begin
            state_n = PAUSE;
            cnt_n   = CW'(PAUSE_LEN - 1);
          end else if (!is_noise) begin
            push     = 1'b1;
            push_evt = '{ext: 1'b0, brk: 1'b0, code: rx_data};
          end
        end
        EXT: begin
          if (rx_data == 8'hF0) state_n = EXT_BRK;
          else if (rx_data != 8'hE0) begin
            push     = 1'b1;
            push_evt = '{ext: 1'b1, brk: 1'b0, code: rx_data};
            state_n  = IDLE;
          end
        end
        // A prefix after F0 is a protocol error: resynchronise without an event.
        BRK: begin
          state_n  = IDLE;
          push     = !is_prefix;
          push_evt = '{ext: 1'b0, brk: 1'b1, code: rx_data};
        end
        EXT_BRK: begin
          state_n  = IDLE;
          push     = !is_prefix;
          push_evt = '{ext: 1'b1, brk: 1'b1, code: rx_data};
        end
        PAUSE: begin
          if (cnt == '0) begin
            push     = 1'b1;
            push_evt = '{ext: 1'b1, brk: 1'b0, code: 8'hE1};
            state_n  = IDLE;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  evt_t               mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, pop, wr, drop;
  evt_t               head;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = evt_rd & ~empty;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      evt_ovf <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         evt_ovf <= 1'b1;
      else if (ovf_clr) evt_ovf <= 1'b0;
    end
  end

  assign head      = mem[rd_ptr];
  assign rx_en     = ~full;
  assign evt_valid = ~empty;
  assign evt_code  = empty ? 8'h00 : head.code;
  assign evt_ext   = ~empty & head.ext;
  assign evt_break = ~empty & head.brk;
endmodule

// File: tb/tb_decodificador_scan_code.sv
// Directed bench for decodificador_scan_code: a queue-based event model checked
// every cycle, plus literal expectations after each directed sequence.
module tb_decodificador_scan_code;
  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       evt_rd;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_ovf;
  logic       ovf_clr;

  decodificador_scan_code dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rx_en(rx_en), .evt_rd(evt_rd), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: events as a queue of {code, ext, brk}, decoded from prefix flags.
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  ev_t  q[$];
  logic m_ovf;
  logic m_ext, m_brk;
  int   pause_left;

  task automatic model_reset();
    q.delete();
    m_ovf      = 1'b0;
    m_ext      = 1'b0;
    m_brk      = 1'b0;
    pause_left = -1;
  endtask

  task automatic decode(input logic [7:0] b, output logic have, output ev_t ev);
    have = 1'b0;
    ev   = '0;
    if (pause_left >= 0) begin
      if (pause_left == 0) begin
        have = 1'b1; ev = '{8'hE1, 1'b1, 1'b0}; pause_left = -1;
      end else pause_left--;
    end else if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) begin
      if (m_brk) begin
        m_ext = 1'b0; m_brk = 1'b0;
      end else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (m_ext) begin
        have = 1'b1; ev = '{8'hE1, 1'b1, 1'b0}; m_ext = 1'b0;
      end else pause_left = 6;
    end else if (!m_ext && !m_brk &&
                 (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF)) begin
      have = 1'b0;
    end else begin
      have = 1'b1; ev = '{b, m_ext, m_brk};
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic model_step();
    logic have, pop, was_full, drop;
    ev_t  ev;
    if (reset) begin
      model_reset();
      return;
    end
    have = 1'b0; ev = '0; drop = 1'b0;
    pop      = evt_rd && (q.size() > 0);
    was_full = (q.size() == 8);
    if (rx_done_tick) decode(rx_data, have, ev);
    if (pop) void'(q.pop_front());
    if (have) begin
      if (!was_full || pop) q.push_back(ev);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  always @(negedge clk) begin
    logic       v;
    logic [7:0] c;
    logic       e, k;
    v = (q.size() > 0);
    c = v ? q[0].code : 8'h00;
    e = v ? q[0].ext  : 1'b0;
    k = v ? q[0].brk  : 1'b0;
    chk("cycle {valid,code,ext,brk,ovf,rx_en}",
        32'({evt_valid, evt_code, evt_ext, evt_break, evt_ovf, rx_en}),
        32'({v, c, e, k, m_ovf, q.size() != 8}));
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_data      = b;
    cyc();
    rx_done_tick = 1'b0;
  endtask

  task automatic pop1();
    evt_rd = 1'b1;
    cyc();
    evt_rd = 1'b0;
  endtask

  function automatic logic [31:0] head();
    return 32'({evt_valid, evt_code, evt_ext, evt_break});
  endfunction

  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; evt_rd = 1'b0; ovf_clr = 1'b0;
    model_reset();
    cyc(); cyc();
    chk("reset evt_valid", 32'(evt_valid), 32'd0);
    chk("reset evt_code",  32'(evt_code),  32'd0);
    chk("reset rx_en",     32'(rx_en),     32'd1);
    chk("reset evt_ovf",   32'(evt_ovf),   32'd0);
    reset = 1'b0;
    cyc();

    send(8'h1C);
    chk("make 1C", head(), 32'({1'b1, 8'h1C, 1'b0, 1'b0}));
    pop1();
    chk("empty after pop", 32'(evt_valid), 32'd0);
    send(8'hF0); send(8'h1C);
    chk("break 1C", head(), 32'({1'b1, 8'h1C, 1'b0, 1'b1}));
    pop1();

    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext make 75", head(), 32'({1'b1, 8'h75, 1'b1, 1'b0}));
    pop1();
    chk("ext break 75", head(), 32'({1'b1, 8'h75, 1'b1, 1'b1}));
    pop1();
    send(8'hAA); send(8'hFA); cyc();
    chk("AA/FA discarded", 32'(evt_valid), 32'd0);

    foreach (pause_seq[i]) send(pause_seq[i]);
    chk("pause event", head(), 32'({1'b1, 8'hE1, 1'b1, 1'b0}));
    chk("model pause count", 32'(q.size()), 32'd1);
    pop1();
    chk("single pause event", 32'(evt_valid), 32'd0);

    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    chk("rx_en low when full", 32'(rx_en), 32'd0);
    send(8'h18);
    chk("ovf after drop", 32'(evt_ovf), 32'd1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("ovf cleared", 32'(evt_ovf), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("ovf drain order", 32'({evt_valid, evt_code}), 32'({1'b1, 8'h10 + 8'(i)}));
      pop1();
    end
    chk("drained", 32'(evt_valid), 32'd0);

    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
    evt_rd = 1'b1; rx_done_tick = 1'b1; rx_data = 8'h28;
    cyc();
    evt_rd = 1'b0; rx_done_tick = 1'b0;
    chk("full push+pop stays full", 32'(rx_en), 32'd0);
    chk("full push+pop no ovf", 32'(evt_ovf), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("wrap order", 32'({evt_valid, evt_code}), 32'({1'b1, 8'h21 + 8'(i)}));
      pop1();
    end

    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
    ovf_clr = 1'b1; rx_done_tick = 1'b1; rx_data = 8'h38;
    cyc();
    ovf_clr = 1'b0; rx_done_tick = 1'b0;
    chk("drop beats ovf_clr", 32'(evt_ovf), 32'd1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    for (int i = 0; i < 8; i++) pop1();

    send(8'h33); send(8'hE0);
    reset = 1'b1;
    model_reset();
    #1;
    chk("outputs during reset",
        32'({evt_valid, evt_code, evt_ext, evt_break, evt_ovf, rx_en}), 32'({1'b0, 8'h00, 3'b000, 1'b1}));
    cyc();
    reset = 1'b0;
    cyc();
    send(8'h1C);
    chk("decode after reset abort", head(), 32'({1'b1, 8'h1C, 1'b0, 1'b0}));
    pop1();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
